// File: rtl/diy_pkg.sv
// rtl/diy_pkg.sv - shared types and pad helpers for the DIY mole table
package diy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECORDING,
    ST_DONE,
    ST_ABORT
  } diy_state_t;

  localparam int LOC_BITS = 3;

  localparam logic [LOC_BITS-1:0] PAD_UPLEFT    = 3'd0;
  localparam logic [LOC_BITS-1:0] PAD_UP        = 3'd1;
  localparam logic [LOC_BITS-1:0] PAD_UPRIGHT   = 3'd2;
  localparam logic [LOC_BITS-1:0] PAD_LEFT      = 3'd3;
  localparam logic [LOC_BITS-1:0] PAD_RIGHT     = 3'd4;
  localparam logic [LOC_BITS-1:0] PAD_DOWNLEFT  = 3'd5;
  localparam logic [LOC_BITS-1:0] PAD_DOWN      = 3'd6;
  localparam logic [LOC_BITS-1:0] PAD_DOWNRIGHT = 3'd7;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Only meaningful for a one-hot vector; the highest set bit wins otherwise.
  function automatic logic [LOC_BITS-1:0] onehot8_to_index(input logic [7:0] v);
    logic [LOC_BITS-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = LOC_BITS'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mole_table_ram.sv
// rtl/mole_table_ram.sv - simple dual-port entry table, synchronous write, registered read
module mole_table_ram #(
  parameter int DEPTH      = 64,
  parameter int INDEX_BITS = 8,
  parameter int WIDTH      = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [INDEX_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr[AW-1:0]] <= wr_data;
  end

  // Read samples the array before this edge's write lands, so a same-index
  // collision returns the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr[AW-1:0]];
  end

endmodule

// File: rtl/diy_recorder.sv
// rtl/diy_recorder.sv - captures pad steps as {music_address, location} entries
// during a DIY recording session and serves them by index for playback.
module diy_recorder
  import diy_pkg::*;
#(
  parameter int MAX_MOLES  = 64,
  parameter int INDEX_BITS = 8,
  parameter int ADDR_BITS  = 23,
  parameter int MIN_GAP    = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  record_enable,
  input  logic                  finish,
  input  logic                  upleft,
  input  logic                  up,
  input  logic                  upright,
  input  logic                  left,
  input  logic                  right,
  input  logic                  downleft,
  input  logic                  down,
  input  logic                  downright,
  input  logic [ADDR_BITS-1:0]  music_address,
  input  logic [INDEX_BITS-1:0] lookup_index,
  output logic [ADDR_BITS-1:0]  index_address,
  output logic [2:0]            index_location,
  output logic [INDEX_BITS-1:0] total_moles,
  output logic                  ready_to_use,
  output logic                  capture_pulse
);

  localparam int ENTRY_BITS = ADDR_BITS + LOC_BITS;
  localparam logic [ADDR_BITS:0]  GAP  = (ADDR_BITS+1)'(MIN_GAP);
  localparam logic [INDEX_BITS:0] FULL = (INDEX_BITS+1)'(MAX_MOLES);

  diy_state_t state, state_d;
  logic [INDEX_BITS-1:0] count, count_d;
  logic [ADDR_BITS-1:0]  last_address, last_address_d;
  logic                  ready_d;
  logic                  record_enable_q;
  logic [7:0]            pad_vec, pad_q, pad_prev;
  logic                  step, gap_ok, accept, last_slot;
  logic [INDEX_BITS-1:0] rd_index;
  logic [ENTRY_BITS-1:0] wr_data, rd_data;

  assign pad_vec = {downright, down, downleft, right, left, upright, up, upleft};

  // A step needs a full release beforehand and exactly one pad now.
  assign step      = (pad_prev == 8'd0) && is_onehot8(pad_q);
  assign gap_ok    = (count == '0) ||
                     ({1'b0, music_address} >= ({1'b0, last_address} + GAP));
  assign accept    = (state == ST_RECORDING) && record_enable && step && gap_ok;
  assign last_slot = (({1'b0, count} + (INDEX_BITS+1)'(1)) == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      count           <= '0;
      last_address    <= '0;
      ready_to_use    <= 1'b0;
      capture_pulse   <= 1'b0;
      record_enable_q <= 1'b0;
      pad_q           <= 8'd0;
      pad_prev        <= 8'd0;
    end else begin
      state           <= state_d;
      count           <= count_d;
      last_address    <= last_address_d;
      ready_to_use    <= ready_d;
      capture_pulse   <= accept;
      record_enable_q <= record_enable;
      pad_q           <= pad_vec;
      pad_prev        <= pad_q;
    end
  end

  always_comb begin
    state_d        = state;
    count_d        = count;
    last_address_d = last_address;
    ready_d        = ready_to_use;
    case (state)
      ST_IDLE: begin
        if (record_enable && !record_enable_q) begin
          count_d = '0;
          ready_d = 1'b0;
          state_d = ST_RECORDING;
        end
      end
      ST_RECORDING: begin
        if (!record_enable) begin
          state_d = ST_ABORT;
        end else begin
          if (accept) begin
            count_d        = count + INDEX_BITS'(1);
            last_address_d = music_address;
          end
          // A finish coinciding with a step closes the table with that step included.
          if ((accept && last_slot) || (finish && (count_d != '0))) begin
            state_d = ST_DONE;
            ready_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        if (!record_enable) state_d = ST_IDLE;
      end
      ST_ABORT: begin
        count_d = '0;
        ready_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_data  = {music_address, onehot8_to_index(pad_q)};
  assign rd_index = (lookup_index >= count) ? '0 : lookup_index;

  mole_table_ram #(
    .DEPTH      (MAX_MOLES),
    .INDEX_BITS (INDEX_BITS),
    .WIDTH      (ENTRY_BITS)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .we      (accept),
    .wr_addr (count),
    .wr_data (wr_data),
    .rd_addr (rd_index),
    .rd_data (rd_data)
  );

  assign index_address  = rd_data[ENTRY_BITS-1:LOC_BITS];
  assign index_location = rd_data[LOC_BITS-1:0];
  assign total_moles    = count;

endmodule

// File: tb/tb_diy_recorder.sv
// tb/tb_diy_recorder.sv - directed bench with a behavioural table model for diy_recorder
module tb_diy_recorder;

  localparam int MAXM = 4;
  localparam int IB   = 8;
  localparam int AB   = 23;
  localparam int GAP  = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          record_enable = 1'b0;
  logic          finish = 1'b0;
  logic [7:0]    pads = 8'd0;
  logic [AB-1:0] music_address = '0;
  logic [IB-1:0] lookup_index = '0;
  logic [AB-1:0] index_address;
  logic [2:0]    index_location;
  logic [IB-1:0] total_moles;
  logic          ready_to_use;
  logic          capture_pulse;

  int checks = 0;
  int errors = 0;
  int cap_seen = 0;

  always #5 clk = ~clk;

  diy_recorder #(
    .MAX_MOLES  (MAXM),
    .INDEX_BITS (IB),
    .ADDR_BITS  (AB),
    .MIN_GAP    (GAP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .record_enable  (record_enable),
    .finish         (finish),
    .upleft         (pads[0]),
    .up             (pads[1]),
    .upright        (pads[2]),
    .left           (pads[3]),
    .right          (pads[4]),
    .downleft       (pads[5]),
    .down           (pads[6]),
    .downright      (pads[7]),
    .music_address  (music_address),
    .lookup_index   (lookup_index),
    .index_address  (index_address),
    .index_location (index_location),
    .total_moles    (total_moles),
    .ready_to_use   (ready_to_use),
    .capture_pulse  (capture_pulse)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: session mode, entry list and pad history.
  int            m_mode;   // 0 idle, 1 recording, 2 done, 3 abort
  int            m_count;
  bit            m_ready;
  bit            m_cap;
  longint        m_last;
  longint        m_addr [MAXM];
  int            m_loc [MAXM];
  bit            m_written [MAXM];
  logic [7:0]    hist0, hist1;
  bit            m_re_prev;
  longint        e_addr;
  int            e_loc;
  bit            e_valid;

  always @(posedge clk or posedge reset) begin : model
    int ri;
    int sl;
    bit is_step;
    bit took;
    if (reset) begin
      m_mode = 0; m_count = 0; m_ready = 0; m_cap = 0; m_last = 0;
      hist0 = 0; hist1 = 0; m_re_prev = 0;
      e_addr = 0; e_loc = 0; e_valid = 0;
    end else begin
      ri      = (int'(lookup_index) >= m_count) ? 0 : int'(lookup_index);
      e_valid = m_written[ri];
      e_addr  = m_addr[ri];
      e_loc   = m_loc[ri];

      is_step = (hist1 == 8'd0) && ($countones(hist0) == 1);
      sl = 0;
      for (int i = 0; i < 8; i++) if (hist0[i]) sl = i;
      m_cap = 0;

      case (m_mode)
        0: if (record_enable && !m_re_prev) begin
             m_count = 0; m_ready = 0; m_mode = 1;
           end
        1: if (!record_enable) m_mode = 3;
           else begin
             took = is_step && (m_count == 0 ||
                                longint'(music_address) >= m_last + GAP);
             if (took) begin
               m_addr[m_count] = longint'(music_address);
               m_loc[m_count]  = sl;
               m_written[m_count] = 1;
               m_count++;
               m_last = longint'(music_address);
               m_cap = 1;
             end
             if (m_count == MAXM || (finish && m_count > 0)) begin
               m_mode = 2; m_ready = 1;
             end
           end
        2: if (!record_enable) m_mode = 0;
        default: begin m_count = 0; m_ready = 0; m_mode = 0; end
      endcase

      hist1 = hist0;
      hist0 = pads;
      m_re_prev = record_enable;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("total_moles", longint'(total_moles), longint'(m_count));
      chk("ready_to_use", longint'(ready_to_use), longint'(m_ready));
      chk("capture_pulse", longint'(capture_pulse), longint'(m_cap));
      if (e_valid) begin
        chk("index_address", longint'(index_address), e_addr);
        chk("index_location", longint'(index_location), longint'(e_loc));
      end
      if (capture_pulse) cap_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step(input int loc, input longint addr);
    music_address = AB'(addr);
    pads = 8'(1 << loc);
    cyc(3);
    pads = 8'd0;
    cyc(3);
  endtask

  task automatic read(input int idx, input longint exp_addr, input int exp_loc);
    lookup_index = IB'(idx);
    cyc(1);
    chk("lit_index_address", longint'(index_address), exp_addr);
    chk("lit_index_location", longint'(index_location), longint'(exp_loc));
  endtask

  task automatic lit(input string name, input longint act, input longint exp);
    chk(name, act, exp);
  endtask

  initial begin : watchdog
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stim
    int c0;
    #1 reset = 1'b1;
    #1;
    lit("reset_total", longint'(total_moles), 0);
    lit("reset_ready", longint'(ready_to_use), 0);
    lit("reset_capture", longint'(capture_pulse), 0);
    lit("reset_index_address", longint'(index_address), 0);
    lit("reset_index_location", longint'(index_location), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc(2);

    // Basic session of three steps
    record_enable = 1'b1;
    cyc(2);
    step(1, 'h1000);
    step(4, 'h3000);
    step(6, 'h8000);
    finish = 1'b1;
    cyc(1);
    finish = 1'b0;
    cyc(1);
    lit("s1_total", longint'(total_moles), 3);
    lit("s1_ready", longint'(ready_to_use), 1);
    read(1, 'h3000, 4);
    read(5, 'h1000, 1);
    read(2, 'h8000, 6);
    record_enable = 1'b0;
    cyc(2);
    lit("s1_idle_ready_held", longint'(ready_to_use), 1);

    // Minimum gap, then abort
    record_enable = 1'b1;
    cyc(2);
    lit("s2_new_ready", longint'(ready_to_use), 0);
    lit("s2_new_total", longint'(total_moles), 0);
    c0 = cap_seen;
    step(1, 'h1000);
    step(1, 'h1800);
    lit("gap_reject_total", longint'(total_moles), 1);
    lit("gap_reject_caps", longint'(cap_seen - c0), 1);
    step(2, 'h2000);
    lit("gap_exact_total", longint'(total_moles), 2);
    step(3, 'h2FFF);
    lit("gap_short_by_one", longint'(total_moles), 2);
    step(3, 'h3000);
    lit("gap_third_total", longint'(total_moles), 3);
    record_enable = 1'b0;
    cyc(3);
    lit("abort_total", longint'(total_moles), 0);
    lit("abort_ready", longint'(ready_to_use), 0);

    // Empty finish, invalid pad patterns, finish coinciding with a step
    record_enable = 1'b1;
    cyc(2);
    finish = 1'b1;
    cyc(1);
    finish = 1'b0;
    cyc(1);
    lit("empty_finish_ready", longint'(ready_to_use), 0);
    c0 = cap_seen;
    pads = 8'b0000_1010;
    cyc(3);
    pads = 8'd0;
    cyc(3);
    lit("two_pad_total", longint'(total_moles), 0);
    music_address = AB'('h10000);
    pads = 8'b0000_0010;
    cyc(1000);
    pads = 8'd0;
    cyc(3);
    lit("held_total", longint'(total_moles), 1);
    lit("held_caps", longint'(cap_seen - c0), 1);
    music_address = AB'('h20000);
    pads = 8'b0001_0000;
    cyc(1);
    finish = 1'b1;
    cyc(1);
    finish = 1'b0;
    pads = 8'd0;
    cyc(3);
    lit("step_finish_total", longint'(total_moles), 2);
    lit("step_finish_ready", longint'(ready_to_use), 1);
    read(1, 'h20000, 4);

    // Table full with five spaced steps
    record_enable = 1'b0;
    cyc(2);
    record_enable = 1'b1;
    cyc(2);
    for (int i = 0; i < 5; i++) step(i, longint'(i + 1) * 'h1000);
    lit("full_total", longint'(total_moles), 4);
    lit("full_ready", longint'(ready_to_use), 1);
    read(7, 'h1000, 0);
    read(3, 'h4000, 3);
    read(4, 'h1000, 0);

    // Asynchronous reset between clock edges
    record_enable = 1'b0;
    cyc(2);
    record_enable = 1'b1;
    cyc(2);
    step(5, 'h1000);
    lit("pre_reset_total", longint'(total_moles), 1);
    c0 = cap_seen;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    lit("async_reset_total", longint'(total_moles), 0);
    lit("async_reset_ready", longint'(ready_to_use), 0);
    lit("async_reset_index", longint'(index_address), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc(6);
    lit("post_reset_total", longint'(total_moles), 0);
    lit("post_reset_caps", longint'(cap_seen - c0), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
